// File: rtl/mult_div_unit.sv
// Multi-cycle multiply/divide unit with HI/LO registers for the MIPS execute stage.
// Define MDU_MADD_EN to enable madd (MDUop 9); otherwise op 9 is a no-op.
module mult_div_unit #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] MDU_opA,
    input  logic [31:0] MDU_opB,
    input  logic [3:0]  MDUop,
    input  logic        MDU_start,
    output logic        MDU_busy,
    output logic [31:0] MDU_result,
    output logic [31:0] HI,
    output logic [31:0] LO
);

    localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CNT_W      = $clog2(MAX_CYCLES + 1);

    localparam logic [3:0] OP_MULT  = 4'd1;
    localparam logic [3:0] OP_MULTU = 4'd2;
    localparam logic [3:0] OP_DIV   = 4'd3;
    localparam logic [3:0] OP_DIVU  = 4'd4;
    localparam logic [3:0] OP_MTHI  = 4'd5;
    localparam logic [3:0] OP_MTLO  = 4'd6;
    localparam logic [3:0] OP_MFHI  = 4'd7;
    localparam logic [3:0] OP_MFLO  = 4'd8;
    localparam logic [3:0] OP_MADD  = 4'd9;

    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_RUN  = 1'b1;

    logic [0:0]       state;
    logic [CNT_W-1:0] cnt;
    logic             long_op;
    logic [CNT_W-1:0] cnt_load;
    logic [63:0]      res_nxt;
    logic             wr_nxt;
    logic [63:0]      res_p1;
    logic             wr_p1;

    // Low 64 bits of a product of sign-extended operands equal the signed product.
    function automatic logic [63:0] mul_signed(input logic signed [31:0] a, input logic signed [31:0] b);
        logic [63:0] ea;
        logic [63:0] eb;
        ea = {{32{a[31]}}, a};
        eb = {{32{b[31]}}, b};
        return ea * eb;
    endfunction

    // Sign-magnitude division: the -2^31 / -1 overflow case falls out as quotient 0x80000000.
    function automatic logic [63:0] div_signed(input logic signed [31:0] a, input logic signed [31:0] b);
        logic [31:0] ua;
        logic [31:0] ub;
        logic [31:0] q;
        logic [31:0] r;
        ua = a[31] ? (32'd0 - a) : a;
        ub = b[31] ? (32'd0 - b) : b;
        q  = (ub == 32'd0) ? 32'd0 : ua / ub;
        r  = (ub == 32'd0) ? 32'd0 : ua % ub;
        if (a[31] ^ b[31]) q = 32'd0 - q;
        if (a[31])         r = 32'd0 - r;
        return {r, q};
    endfunction

    function automatic logic [63:0] div_unsigned(input logic [31:0] a, input logic [31:0] b);
        if (b == 32'd0) return 64'd0;
        return {a % b, a / b};
    endfunction

    always_comb begin
        long_op  = 1'b0;
        cnt_load = CNT_W'(MULT_CYCLES);
        res_nxt  = 64'd0;
        wr_nxt   = 1'b0;
        case (MDUop)
            OP_MULT:  begin long_op = 1'b1; wr_nxt = 1'b1; res_nxt = mul_signed(MDU_opA, MDU_opB); end
            OP_MULTU: begin long_op = 1'b1; wr_nxt = 1'b1; res_nxt = {32'd0, MDU_opA} * {32'd0, MDU_opB}; end
            OP_DIV: begin
                long_op  = 1'b1;
                cnt_load = CNT_W'(DIV_CYCLES);
                wr_nxt   = (MDU_opB != 32'd0);
                res_nxt  = div_signed(MDU_opA, MDU_opB);
            end
            OP_DIVU: begin
                long_op  = 1'b1;
                cnt_load = CNT_W'(DIV_CYCLES);
                wr_nxt   = (MDU_opB != 32'd0);
                res_nxt  = div_unsigned(MDU_opA, MDU_opB);
            end
`ifdef MDU_MADD_EN
            OP_MADD:  begin long_op = 1'b1; wr_nxt = 1'b1; res_nxt = {HI, LO} + mul_signed(MDU_opA, MDU_opB); end
`endif
            default: ;
        endcase
    end

    // p0 -> p1: result is computed at issue and parked until the countdown ends.
    always_ff @(posedge clk) begin
        if (state == S_IDLE && MDU_start && long_op) begin
            res_p1 <= res_nxt;
            wr_p1  <= wr_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= S_IDLE;
            cnt   <= '0;
            HI    <= 32'd0;
            LO    <= 32'd0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (MDU_start) begin
                        if (long_op) begin
                            state <= S_RUN;
                            cnt   <= cnt_load;
                        end else if (MDUop == OP_MTHI) begin
                            HI <= MDU_opA;
                        end else if (MDUop == OP_MTLO) begin
                            LO <= MDU_opA;
                        end
                    end
                end
                default: begin
                    if (cnt == CNT_W'(1)) begin
                        state <= S_IDLE;
                        cnt   <= '0;
                        if (wr_p1) begin
                            HI <= res_p1[63:32];
                            LO <= res_p1[31:0];
                        end
                    end else begin
                        cnt <= cnt - CNT_W'(1);
                    end
                end
            endcase
        end
    end

    assign MDU_busy = (state == S_RUN);

    always_comb begin
        case (MDUop)
            OP_MFHI: MDU_result = HI;
            OP_MFLO: MDU_result = LO;
            default: MDU_result = 32'd0;
        endcase
    end

endmodule

// File: tb/tb_mult_div_unit.sv
// Self-checking bench for mult_div_unit: vector table, scoreboard queue, hand-written corner sequences.
module tb_mult_div_unit;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] opA = 32'd0;
    logic [31:0] opB = 32'd0;
    logic [3:0]  MDUop = 4'd0;
    logic        start = 1'b0;
    logic        busy;
    logic [31:0] result;
    logic [31:0] hi;
    logic [31:0] lo;

    int checks = 0;
    int errors = 0;
    logic [31:0] hi_m = 32'd0;
    logic [31:0] lo_m = 32'd0;

    typedef struct {
        logic [3:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] hi;
        logic [31:0] lo;
        int          n;
    } vec_t;

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
        int          n;
    } exp_t;

    vec_t vecs[9];
    exp_t sb[$];

    mult_div_unit #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
        .clk(clk), .reset(reset), .MDU_opA(opA), .MDU_opB(opB), .MDUop(MDUop),
        .MDU_start(start), .MDU_busy(busy), .MDU_result(result), .HI(hi), .LO(lo)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic run_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] ehi, input logic [31:0] elo, input int n, input int inject);
        exp_t e;
        int cnt;
        @(negedge clk);
        MDUop = op; opA = a; opB = b; start = 1'b1;
        sb.push_back('{ehi, elo, n});
        @(negedge clk);
        start = 1'b0; MDUop = 4'd7; #1;
        check("mfhi_in_flight", result, hi_m);
        cnt = 0;
        while (busy && cnt < 64) begin
            cnt++;
            if (cnt == inject) begin
                start = 1'b1; MDUop = 4'd1; opA = 32'd1; opB = 32'd1;
            end else begin
                start = 1'b0; MDUop = 4'd0;
            end
            @(negedge clk); #1;
        end
        start = 1'b0; MDUop = 4'd0;
        if (cnt >= 64) begin
            checks++; errors++;
            $display("FAIL busy_timeout: got %0d cycles required %0d", cnt, n);
        end
        if (sb.size() == 0) begin
            checks++; errors++;
            $display("FAIL scoreboard_empty: got 0 entries required 1");
        end else begin
            e = sb.pop_front();
            check("busy_cycles", 32'(cnt), 32'(e.n));
            check("HI", hi, e.hi);
            check("LO", lo, e.lo);
            MDUop = 4'd8; #1;
            check("mflo", result, e.lo);
            MDUop = 4'd0;
            hi_m = e.hi; lo_m = e.lo;
        end
        @(negedge clk); #1;
        check("no_ghost_start", {31'd0, busy}, 32'd0);
    endtask

    task automatic move_to(input logic [3:0] op, input logic [31:0] val);
        @(negedge clk);
        MDUop = op; opA = val; start = 1'b1;
        if (op == 4'd5) hi_m = val; else lo_m = val;
        @(negedge clk);
        start = 1'b0; MDUop = 4'd8; #1;
        check("mt_busy", {31'd0, busy}, 32'd0);
        check("mt_mflo", result, lo_m);
        @(negedge clk);
        MDUop = 4'd7; #1;
        check("mt_mfhi", result, hi_m);
        MDUop = 4'd0;
    endtask

    initial begin
        vecs[0] = '{4'd1, 32'hFFFFFFFE, 32'h00000003, 32'hFFFFFFFF, 32'hFFFFFFFA, 5};
        vecs[1] = '{4'd2, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 5};
        vecs[2] = '{4'd3, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD, 10};
        vecs[3] = '{4'd4, 32'h00000007, 32'h00000000, 32'hFFFFFFFF, 32'hFFFFFFFD, 10};
        vecs[4] = '{4'd3, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 10};
        vecs[5] = '{4'd4, 32'd100,      32'd7,        32'd2,        32'd14,       10};
        vecs[6] = '{4'd1, 32'd7,        32'hFFFFFFFD, 32'hFFFFFFFF, 32'hFFFFFFEB, 5};
        vecs[7] = '{4'd3, 32'd7,        32'hFFFFFFFE, 32'd1,        32'hFFFFFFFD, 10};
        vecs[8] = '{4'd2, 32'h00010000, 32'h00010000, 32'd1,        32'd0,        5};

        repeat (3) @(negedge clk);
        reset = 1'b0;
        MDUop = 4'd7; #1;
        check("reset_busy", {31'd0, busy}, 32'd0);
        check("reset_HI", hi, 32'd0);
        check("reset_LO", lo, 32'd0);
        check("reset_mfhi", result, 32'd0);
        MDUop = 4'd0;

        for (int i = 0; i < 9; i++)
            run_op(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].hi, vecs[i].lo, vecs[i].n, 0);

        move_to(4'd5, 32'h12345678);
        move_to(4'd6, 32'hCAFEF00D);

        // starts issued mid-run and on the commit cycle must be dropped
        run_op(4'd4, 32'd100, 32'd7, 32'd2, 32'd14, 10, 2);
        run_op(4'd1, 32'd3, 32'd3, 32'd0, 32'd9, 5, 5);

        // reset during busy cycle 4 aborts the divide
        @(negedge clk);
        MDUop = 4'd3; opA = 32'd50; opB = 32'd3; start = 1'b1;
        @(negedge clk);
        start = 1'b0; MDUop = 4'd0;
        repeat (3) @(negedge clk);
        #1;
        check("pre_reset_busy", {31'd0, busy}, 32'd1);
        reset = 1'b1;
        @(negedge clk); #1;
        reset = 1'b0;
        check("abort_busy", {31'd0, busy}, 32'd0);
        check("abort_HI", hi, 32'd0);
        check("abort_LO", lo, 32'd0);
        hi_m = 32'd0; lo_m = 32'd0;
        @(negedge clk); #1;
        check("abort_stays_idle", {31'd0, busy}, 32'd0);

        move_to(4'd5, 32'd0);
        move_to(4'd6, 32'hFFFFFFFF);
`ifdef MDU_MADD_EN
        run_op(4'd9, 32'd1, 32'd1, 32'd1, 32'd0, 5, 0);
`else
        run_op(4'd9, 32'd1, 32'd1, 32'd0, 32'hFFFFFFFF, 0, 0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got no finish required finish before 200000");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/mult_div_unit.md
# mult_div_unit

- Multi-cycle multiply/divide unit with HI/LO registers for the MIPS pipeline execute stage; sits beside the combinational ALU.
- Accepts mult/multu/div/divu/mthi/mtlo from the E stage, holds the pipeline off via a busy flag, and serves mfhi/mflo reads.
- Fills the long-latency half of the arithmetic path that the single-cycle ALU does not cover; the stall unit consumes `MDU_busy`.

## Interface
- `MULT_CYCLES`, default 5: busy cycles for mult/multu (≥1).
- `DIV_CYCLES`, default 10: busy cycles for div/divu (≥1).

- `clk` in 1: single clock, rising edge.
- `reset` in 1: synchronous, active-high.
- `MDU_opA` in 32: rs operand.
- `MDU_opB` in 32: rt operand.
- `MDUop` in 4: 0 none, 1 mult, 2 multu, 3 div, 4 divu, 5 mthi, 6 mtlo, 7 mfhi, 8 mflo, 9 madd (only with `MDU_MADD_EN`).
- `MDU_start` in 1: qualifies `MDUop` for one cycle.
- `MDU_busy` out 1: operation in flight.
- `MDU_result` out 32: read port.
  - `MDUop`=7 → HI; `MDUop`=8 → LO; else 0.
  - Combinational, independent of `MDU_start`.
- `HI`, `LO` out 32 each: architectural registers, for debug/trace.

## Operation
- State machine: IDLE, RUN.
  - IDLE → RUN on `MDU_start` with `MDUop` ∈ {1,2,3,4,9}: operands latched, counter loaded with N (`MULT_CYCLES` or `DIV_CYCLES`).
  - RUN: counter decrements each cycle; at count 1 the latched result is committed to HI/LO and the state returns to IDLE.
- Arithmetic:
  - mult: signed 32×32 → 64; HI = [63:32], LO = [31:0].
  - multu: same, unsigned.
  - div: LO = signed quotient, truncated toward zero; HI = remainder, sign of dividend.
  - divu: same, unsigned.
  - 0x80000000 / 0xFFFFFFFF (signed): LO = 0x80000000, HI = 0.
  - Divide by zero (div/divu): busy still runs for `DIV_CYCLES`; HI/LO unchanged at commit.
- mthi/mtlo: when `MDU_start` is high in IDLE, HI (resp. LO) ← `MDU_opA` at that edge; no busy.
- Ignored requests: `MDU_start` while `MDU_busy` is high has no effect (stall logic must not issue one). mthi/mtlo during RUN are also ignored.
- Result computation may be done at start and held in shadow registers; only the visible timing is normative.

## Timing
- Reset: `MDU_busy` = 0, HI = 0, LO = 0, state IDLE, counter 0.
- Reset mid-operation: aborts the operation; no commit; HI/LO = 0 on the next cycle.
- Start sampled at edge t:
  - `MDU_busy` is high during cycles t+1 … t+N.
  - HI/LO take the new value at the edge ending cycle t+N.
  - From cycle t+N+1: busy low and new HI/LO visible.
- Back-to-back: a new start is accepted in the first cycle busy is low.
- mthi/mtlo: visible on `HI`/`LO`/`MDU_result` the cycle after the edge.
- mfhi/mflo: zero latency. During RUN they return the old HI/LO; the pipeline stalls them on busy.
- Simultaneous events:
  - Reset wins over start.
  - A start in the same cycle as the RUN commit is ignored, because busy is still high.

## Configuration
- `MDU_MADD_EN` defined: `MDUop`=9 (madd) is legal.
  - Signed 64-bit product of opA×opB is added to {HI,LO}, modulo 2^64.
  - Busy for `MULT_CYCLES`.
- Undefined: `MDUop`=9 is treated as 0; no start, no busy, HI/LO unchanged.

## Test plan
- Reset, then mult 0xFFFFFFFE × 0x00000003 → busy high 5 cycles; then HI=0xFFFFFFFF, LO=0xFFFFFFFA.
- multu 0xFFFFFFFF × 0xFFFFFFFF → HI=0xFFFFFFFE, LO=0x00000001 after 5 busy cycles.
- div −7 / 2 → LO=0xFFFFFFFD, HI=0xFFFFFFFF. divu 7 / 0 → busy 10 cycles; HI/LO keep prior values.
- mthi 0x12345678, then mflo/mfhi → `MDU_result` = LO then 0x12345678 the next cycle; no busy.
- Issue div, assert reset at busy cycle 4 → busy=0, HI=LO=0 next cycle. Issue a second start during busy → ignored (busy count unchanged).
- With `MDU_MADD_EN`: HI=0, LO=0xFFFFFFFF, madd 1 × 1 → HI=1, LO=0. Without the macro: same stimulus → no busy, HI/LO unchanged.
